// File: rtl/byte_lane_reader.sv
`default_nettype none
// ============================================================================
//  Module      : byte_lane_reader
//  Description : Single-outstanding load path between the processor and a
//                24-bit data memory. Fetches one word, extracts the byte
//                chosen by a one-hot 3-bit byte enable and returns it
//                right-aligned on an 18-bit bus. Illegal enables return an
//                error response without touching memory.
//  Options     : BYTE_READ_SIGN_EXT_EN - defined: signed load (bit 7 of the
//                byte replicated into bits 17:8); undefined: zero-extended.
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_lane_reader #(
    parameter int ADDR_W  = 16,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_byteena,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [23:0]       mem_rdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [17:0]       resp_data,
    output logic              resp_err
);

    // Latency counter start value; MEM_LAT is limited to 1..7.
    localparam logic [2:0] c_lat_init = 3'(MEM_LAT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [2:0]          be_q,    be_d;
    logic [2:0]          cnt_q,   cnt_d;
    logic [17:0]         data_q,  data_d;
    logic                err_q,   err_d;

    logic                be_legal;
    logic [7:0]          sel_byte;
    logic [9:0]          ext_bits;

    // Exactly one lane bit set is the only legal enable pattern.
    assign be_legal = (req_byteena == 3'b001) ||
                      (req_byteena == 3'b010) ||
                      (req_byteena == 3'b100);

    // Lane mux driven by the latched enable; only meaningful in the capture cycle.
    always_comb begin
        sel_byte = mem_rdata[7:0];
        case (be_q)
            3'b100:  sel_byte = mem_rdata[23:16];
            3'b010:  sel_byte = mem_rdata[15:8];
            default: sel_byte = mem_rdata[7:0];
        endcase
    end

`ifdef BYTE_READ_SIGN_EXT_EN
    assign ext_bits = {10{sel_byte[7]}};
`else
    assign ext_bits = 10'd0;
`endif

    // State and datapath registers; reset wins over everything, mid-flight included.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            be_q    <= 3'd0;
            cnt_q   <= 3'd0;
            data_q  <= 18'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: accept, issue the read, count down the latency, respond.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        be_d    = be_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    be_d = req_byteena;
                    if (be_legal) begin
                        // Address only moves for real reads so mem_addr holds otherwise.
                        addr_d  = req_addr;
                        state_d = S_ISSUE;
                    end else begin
                        data_d  = 18'd0;
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end
                end
            end
            S_ISSUE: begin
                cnt_d   = c_lat_init;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == 3'd1) begin
                    data_d  = {ext_bits, sel_byte};
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign req_ready  = (state_q == S_IDLE) && !rst;
    assign mem_rd_en  = (state_q == S_ISSUE);
    assign mem_addr   = addr_q;
    assign resp_valid = (state_q == S_RESP);
    assign resp_data  = data_q;
    assign resp_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_byte_lane_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_byte_lane_reader
//  Description : Self-checking bench for byte_lane_reader. Two instances
//                (MEM_LAT 1 and 3) share a clock and a bench-side memory;
//                a per-instance responder returns the word MEM_LAT cycles
//                after each read strobe and drives random garbage otherwise.
//  Options     : BYTE_READ_SIGN_EXT_EN selects signed expected values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_byte_lane_reader;

    logic        clk = 1'b0;
    logic        rst;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_err = 0;

    logic        req_valid   [2];
    logic        req_ready   [2];
    logic [15:0] req_addr    [2];
    logic [2:0]  req_byteena [2];
    logic        mem_rd_en   [2];
    logic [15:0] mem_addr    [2];
    logic [23:0] mem_rdata   [2];
    logic        resp_valid  [2];
    logic        resp_ready  [2];
    logic [17:0] resp_data   [2];
    logic        resp_err    [2];

    logic [23:0] mem [256];
    logic [17:0] exp_data [2];
    logic        exp_err  [2];

    // Free-running clock and cycle index (index changes on the rising edge).
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Device instances plus a memory responder for each.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        byte_lane_reader #(
            .ADDR_W  (16),
            .MEM_LAT (g == 0 ? 1 : 3)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .req_valid   (req_valid[g]),
            .req_ready   (req_ready[g]),
            .req_addr    (req_addr[g]),
            .req_byteena (req_byteena[g]),
            .mem_rd_en   (mem_rd_en[g]),
            .mem_addr    (mem_addr[g]),
            .mem_rdata   (mem_rdata[g]),
            .resp_valid  (resp_valid[g]),
            .resp_ready  (resp_ready[g]),
            .resp_data   (resp_data[g]),
            .resp_err    (resp_err[g])
        );

        bit   pend_v   = 1'b0;
        int   pend_due = 0;
        logic [7:0] pend_a = 8'd0;

        always @(negedge clk) begin
            if (pend_v && cyc == pend_due) begin
                mem_rdata[g] = mem[pend_a];
                pend_v       = 1'b0;
            end else begin
                mem_rdata[g] = 24'($urandom);
            end
            if (mem_rd_en[g] === 1'b1) begin
                pend_v   = 1'b1;
                pend_due = cyc + (g == 0 ? 1 : 3);
                pend_a   = mem_addr[g][7:0];
            end
        end
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    // Reference: {err, data} from the word and enable, by plain arithmetic.
    function automatic logic [18:0] ref_model(input logic [23:0] w, input logic [2:0] be);
        int lane;
        int b;
        int v;
        if ($countones(be) != 1) return {1'b1, 18'd0};
        lane = (be == 3'b001) ? 0 : (be == 3'b010) ? 1 : 2;
        b = int'((w >> (8 * lane)) & 24'hFF);
        v = b;
`ifdef BYTE_READ_SIGN_EXT_EN
        if (b >= 128) v = b - 256;
`endif
        return {1'b0, 18'(v)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present one request and follow it up to the first response cycle.
    task automatic issue(input int k, input logic [15:0] addr, input logic [2:0] be);
        logic [18:0] e;
        logic [15:0] prev_addr;
        logic [15:0] seen_addr;
        int t_acc, t_rd, n_rd, i;
        bit got, legal;
        legal       = ($countones(be) == 1);
        e           = ref_model(mem[addr[7:0]], be);
        exp_data[k] = e[17:0];
        exp_err[k]  = e[18];
        prev_addr   = mem_addr[k];
        for (i = 0; i < 20 && req_ready[k] !== 1'b1; i++) @(negedge clk);
        check("ready_before_req", 32'(req_ready[k]), 32'd1);
        req_valid[k]   = 1'b1;
        req_addr[k]    = addr;
        req_byteena[k] = be;
        t_acc          = cyc;
        @(negedge clk);
        req_valid[k] = 1'b0;
        n_rd = 0;
        t_rd = -1;
        got  = 1'b0;
        seen_addr = 16'd0;
        for (i = 0; i < 20; i++) begin
            if (mem_rd_en[k] === 1'b1) begin
                n_rd++;
                if (t_rd < 0) begin
                    t_rd      = cyc;
                    seen_addr = mem_addr[k];
                end
            end
            if (resp_valid[k] === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("resp_arrived", 32'(got), 32'd1);
        check("resp_latency", 32'(cyc - t_acc), legal ? 32'(2 + lat_of(k)) : 32'd1);
        check("rd_en_pulses", 32'(n_rd), legal ? 32'd1 : 32'd0);
        if (legal) begin
            check("rd_en_timing", 32'(t_rd - t_acc), 32'd1);
            check("mem_addr", 32'(seen_addr), 32'(addr));
        end else begin
            check("mem_addr_hold", 32'(mem_addr[k]), 32'(prev_addr));
        end
        check("resp_data", 32'(resp_data[k]), 32'(exp_data[k]));
        check("resp_err", 32'(resp_err[k]), 32'(exp_err[k]));
    endtask

    // Hold the response for 'stall' extra cycles, then handshake. With hold_req
    // an illegal request waits during the stall and must be taken right after.
    task automatic complete(input int k, input int stall, input bit hold_req);
        if (hold_req) begin
            req_valid[k]   = 1'b1;
            req_byteena[k] = 3'b111;
            req_addr[k]    = 16'hBEEF;
        end
        repeat (stall) begin
            @(negedge clk);
            check("stall_valid", 32'(resp_valid[k]), 32'd1);
            check("stall_data", 32'(resp_data[k]), 32'(exp_data[k]));
            check("stall_err", 32'(resp_err[k]), 32'(exp_err[k]));
            check("stall_req_ready", 32'(req_ready[k]), 32'd0);
        end
        resp_ready[k] = 1'b1;
        @(negedge clk);
        check("post_hs_valid", 32'(resp_valid[k]), 32'd0);
        check("post_hs_ready", 32'(req_ready[k]), 32'd1);
        if (hold_req) begin
            @(negedge clk);
            req_valid[k] = 1'b0;
            check("follow_valid", 32'(resp_valid[k]), 32'd1);
            check("follow_err", 32'(resp_err[k]), 32'd1);
            check("follow_data", 32'(resp_data[k]), 32'd0);
            check("follow_no_rd", 32'(mem_rd_en[k]), 32'd0);
            @(negedge clk);
            check("follow_done", 32'(resp_valid[k]), 32'd0);
        end
    endtask

    task automatic txn(input int k, input logic [15:0] addr, input logic [2:0] be,
                       input int stall, input bit hold_req);
        resp_ready[k] = (stall == 0);
        issue(k, addr, be);
        complete(k, stall, hold_req);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            req_valid[k]   = 1'b0;
            req_addr[k]    = 16'd0;
            req_byteena[k] = 3'd0;
            resp_ready[k]  = 1'b1;
        end
        for (int a = 0; a < 256; a++) mem[a] = 24'($urandom);
        mem[8'h10] = 24'hA1B2C3;
        mem[8'h11] = 24'h00807F;
        mem[8'h20] = 24'h123456;
        mem[8'h21] = 24'h00FF00;

        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("rst_req_ready", 32'(req_ready[k]), 32'd0);
            check("rst_rd_en", 32'(mem_rd_en[k]), 32'd0);
            check("rst_mem_addr", 32'(mem_addr[k]), 32'd0);
            check("rst_resp_valid", 32'(resp_valid[k]), 32'd0);
            check("rst_resp_data", 32'(resp_data[k]), 32'd0);
            check("rst_resp_err", 32'(resp_err[k]), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) check("ready_after_rst", 32'(req_ready[k]), 32'd1);

        // Directed lanes, MEM_LAT = 1.
        txn(0, 16'h0010, 3'b001, 0, 1'b0);
        txn(0, 16'h0010, 3'b100, 0, 1'b0);
        txn(0, 16'h0010, 3'b010, 0, 1'b0);
        txn(0, 16'h0011, 3'b001, 0, 1'b0);
        txn(0, 16'h0011, 3'b010, 0, 1'b0);
        // Illegal enables.
        txn(0, 16'h0030, 3'b011, 0, 1'b0);
        txn(0, 16'h0030, 3'b000, 0, 1'b0);
        txn(0, 16'h0030, 3'b111, 0, 1'b0);
        // Stalled response with a waiting request.
        txn(0, 16'h0010, 3'b100, 5, 1'b1);
        // MEM_LAT = 3 with garbage on the bus outside the capture cycle.
        txn(1, 16'h0020, 3'b010, 0, 1'b0);

        // Reset while waiting for memory: the late word must be dropped.
        resp_ready[1]  = 1'b1;
        req_valid[1]   = 1'b1;
        req_addr[1]    = 16'h0021;
        req_byteena[1] = 3'b010;
        @(negedge clk);
        req_valid[1] = 1'b0;
        check("rstw_issue", 32'(mem_rd_en[1]), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstw_valid", 32'(resp_valid[1]), 32'd0);
        check("rstw_ready_in_rst", 32'(req_ready[1]), 32'd0);
        check("rstw_rd_en", 32'(mem_rd_en[1]), 32'd0);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("rstw_no_resp", 32'(resp_valid[1]), 32'd0);
            check("rstw_idle_ready", 32'(req_ready[1]), 32'd1);
            check("rstw_data_clear", 32'(resp_data[1]), 32'd0);
        end
        txn(1, 16'h0020, 3'b100, 0, 1'b0);

        // Randomized traffic on both latencies.
        for (int n = 0; n < 40; n++) begin
            int k;
            k = int'($urandom_range(1, 0));
            txn(k, 16'($urandom), 3'($urandom_range(7, 0)), int'($urandom_range(3, 0)), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
